// File: rtl/banked_mem_resp.sv
// Four-bank word-interleaved memory responder for the cache controller's mem_rd/mem_wr port.
// Bank = addr[2:1], row = addr[3+ROW_BITS-1:3]; each access holds its bank for four cycles.
module banked_mem_resp #(
  parameter int ROW_BITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int DEPTH = 2 ** (ROW_BITS + 2);

  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic                present;
  logic                accept;

  logic [1:0]          occ [4];
  logic [15:0]         mem [DEPTH];

  logic                s1_valid;
  logic [1:0]          s1_bank;
  logic [ROW_BITS-1:0] s1_row;
  logic                s2_valid;
  logic [15:0]         s2_data;

  assign bank    = addr[2:1];
  assign row     = addr[3+ROW_BITS-1:3];
  assign present = rd | wr;
  assign err     = present & ((rd & wr) | addr[0]);
  assign stall   = present & ~err & busy[bank];
  // Nothing is accepted while reset is sampled, so a write in that cycle is lost.
  assign accept  = present & ~err & ~stall & ~rst;

  always_comb begin
    busy = '0;
    for (int b = 0; b < 4; b++) busy[b] = (occ[b] != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) occ[b] <= 2'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) occ[b] <= 2'd3;
        else if (occ[b] != 2'd0)       occ[b] <= occ[b] - 2'd1;
      end
    end
  end

  // Storage has no reset; a same-bank write cannot collide with a pending read fetch.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[{bank, row}] <= data_in;
    s2_data <= mem[{s1_bank, s1_row}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= 2'd0;
      s1_row   <= '0;
      s2_valid <= 1'b0;
      rd_valid <= 1'b0;
      data_out <= 16'h0;
    end else begin
      s1_valid <= accept & rd;
      s1_bank  <= bank;
      s1_row   <= row;
      s2_valid <= s1_valid;
      rd_valid <= s2_valid;
      data_out <= s2_valid ? s2_data : 16'h0;
    end
  end

endmodule

// File: tb/tb_banked_mem_resp.sv
// Bench for banked_mem_resp: directed request sequences checked every cycle against a
// cycle-stamped behavioural model, plus literal expectations on the returned data.
module tb_banked_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, data_in, data_out;
  logic        rd, wr, rd_valid, stall, err;
  logic [3:0]  busy;

  always #5 clk = ~clk;

  banked_mem_resp #(.ROW_BITS(13)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .rd_valid(rd_valid), .stall(stall), .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: edge counter, last accept edge per bank, word store, and a queue of due reads.
  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_t;

  int          cyc = 0;
  int          last_acc [4];
  rd_t         rq [$];
  logic [15:0] mdl_mem [int];
  logic [15:0] got_data [$];
  int          got_cyc [$];

  function automatic bit mbusy(input int b);
    return ((cyc - last_acc[b]) >= 0) && ((cyc - last_acc[b]) <= 2);
  endfunction

  always @(posedge clk) begin : model
    bit  m_pres, m_err, m_stall;
    int  b, key;
    rd_t e;
    m_pres  = rd | wr;
    m_err   = m_pres && ((rd && wr) || addr[0]);
    b       = int'(addr[2:1]);
    m_stall = m_pres && !m_err && mbusy(b);
    key     = int'(addr[15:1]);
    cyc++;
    if (rst) begin
      rq.delete();
      for (int i = 0; i < 4; i++) last_acc[i] = -100;
    end else if (m_pres && !m_err && !m_stall) begin
      last_acc[b] = cyc;
      if (wr) mdl_mem[key] = data_in;
      else begin
        e.due   = cyc + 2;
        e.known = mdl_mem.exists(key);
        e.data  = e.known ? mdl_mem[key] : 16'h0;
        rq.push_back(e);
      end
    end
  end

  logic [3:0] c_busy;
  logic       c_pres, c_err, c_stall;

  always @(negedge clk) begin : compare
    if (cyc >= 1) begin
      for (int i = 0; i < 4; i++) c_busy[i] = mbusy(i);
      c_pres  = rd | wr;
      c_err   = c_pres & ((rd & wr) | addr[0]);
      c_stall = c_pres & ~c_err & c_busy[addr[2:1]];
      check("busy", busy, c_busy);
      check("err", err, c_err);
      check("stall", stall, c_stall);
      if (rq.size() > 0 && rq[0].due == cyc) begin
        check("rd_valid", rd_valid, 1);
        if (rq[0].known) check("data_out", data_out, rq[0].data);
        void'(rq.pop_front());
      end else begin
        check("rd_valid_idle", rd_valid, 0);
        check("data_out_idle", data_out, 0);
      end
      if (rd_valid === 1'b1) begin
        got_data.push_back(data_out);
        got_cyc.push_back(cyc);
      end
    end
  end

  logic last_stall, last_err;

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    last_stall = stall;
    last_err   = err;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic expect_got(input string name, input int g0, input logic [15:0] v0,
                            input logic [15:0] v1, input int cnt);
    check({name, "_count"}, got_data.size() - g0, cnt);
    if (got_data.size() - g0 >= 1) check({name, "_v0"}, got_data[g0], v0);
    if (cnt == 2 && got_data.size() - g0 >= 2) check({name, "_v1"}, got_data[g0+1], v1);
  endtask

  logic [15:0] wv [4];
  logic        stall_exp [4];
  int          g0, t0;

  initial begin
    for (int i = 0; i < 4; i++) last_acc[i] = -100;
    wv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    stall_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err, 0);

    // Streamed writes then streamed reads across banks 0-3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0100 + 16'(2*i), wv[i]);
      check("wr_stream_stall", last_stall, 0);
    end
    g0 = got_data.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0100 + 16'(2*i), 16'h0);
      check("rd_stream_stall", last_stall, 0);
      if (i == 0) t0 = cyc;
    end
    idle(4);
    check("rd_stream_count", got_data.size() - g0, 4);
    if (got_data.size() - g0 == 4) begin
      for (int i = 0; i < 4; i++) check("rd_stream_data", got_data[g0+i], wv[i]);
      check("rd_stream_latency", got_cyc[g0] - t0, 2);
      check("rd_stream_back2back", got_cyc[g0+3] - got_cyc[g0], 3);
    end

    // Same-bank conflict: stalled for three cycles, accepted on the fourth.
    drive(1'b0, 1'b1, 16'h0108, 16'h5555);
    idle(3);
    g0 = got_data.size();
    drive(1'b1, 1'b0, 16'h0100, 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0108, 16'h0);
      check("conflict_stall", last_stall, stall_exp[i]);
    end
    idle(4);
    expect_got("conflict", g0, 16'h1111, 16'h5555, 2);

    // Illegal requests to a busy bank report err only and change nothing.
    drive(1'b0, 1'b1, 16'h0200, 16'hAAAA);
    drive(1'b1, 1'b1, 16'h0200, 16'h1234);
    check("rdwr_err", last_err, 1);
    check("rdwr_stall", last_stall, 0);
    g0 = got_data.size();
    drive(1'b1, 1'b0, 16'h0201, 16'h0);
    check("misalign_err", last_err, 1);
    check("misalign_stall", last_stall, 0);
    idle(2);
    drive(1'b1, 1'b0, 16'h0200, 16'h0);
    idle(4);
    expect_got("illegal", g0, 16'hAAAA, 16'h0, 1);

    // Reset drops an in-flight read and discards a write sampled with reset.
    g0 = got_data.size();
    drive(1'b1, 1'b0, 16'h0102, 16'h0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0106, 16'hDEAD);
    rst = 1'b0;
    check("post_rst_busy", busy, 0);
    drive(1'b1, 1'b0, 16'h0102, 16'h0);
    check("post_rst_stall", last_stall, 0);
    drive(1'b1, 1'b0, 16'h0106, 16'h0);
    idle(4);
    expect_got("reset_mid", g0, 16'h2222, 16'h4444, 2);

    // Write to another bank while a read is in flight.
    drive(1'b0, 1'b1, 16'h0000, 16'h0BAD);
    idle(3);
    g0 = got_data.size();
    drive(1'b1, 1'b0, 16'h0000, 16'h0);
    drive(1'b0, 1'b1, 16'h0004, 16'hBEEF);
    check("inflight_wr_stall", last_stall, 0);
    idle(3);
    drive(1'b1, 1'b0, 16'h0004, 16'h0);
    check("reread_stall", last_stall, 0);
    idle(4);
    expect_got("inflight", g0, 16'h0BAD, 16'hBEEF, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
